// File: rtl/joy2quad_pkg.sv
// Shared types and constants for the multi-channel joystick-to-quadrature encoder.
// The Gray lookup sets the AB order that the game core decodes as wheel rotation.
package joy2quad_pkg;

    typedef enum logic [1:0] {NONE, RIGHT, LEFT} dir_t;
    typedef enum logic [1:0] {IDLE, RUN_R, RUN_L} state_t;

    localparam int ACCEL_STEPS     = 8;
    localparam int ACCEL_MAX_LEVEL = 3;

    // Exactly one of A/B toggles per phase increment, like a real optical wheel.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        case (phase)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/joy2quad_chan.sv
// One steering channel: direction FSM, step-period counter, acceleration ramp,
// quadrature phase and wrap-around position counter, all in one registered block.
module joy2quad_chan
    import joy2quad_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int POS_W = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             accel_en,
    input  logic             left,
    input  logic             right,
    output logic [1:0]       steer,
    output logic [POS_W-1:0] position,
    output logic             stepped
);

    state_t           state;
    state_t           target;
    dir_t             dir;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] period;
    logic [1:0]       level;
    logic [1:0]       eff_level;
    logic [2:0]       held;
    logic [1:0]       phase;
    logic [1:0]       next_phase;
    logic             terminal;

    always_comb begin
        dir = NONE;
        if (right && !left) begin
            dir = RIGHT;
        end else if (left && !right) begin
            dir = LEFT;
        end
    end

    always_comb begin
        case (dir)
            RIGHT:   target = RUN_R;
            LEFT:    target = RUN_L;
            default: target = IDLE;
        endcase
    end

    // Using >= rather than == lets a shrinking clkdiv fire immediately instead of overrunning.
    always_comb begin
        eff_level  = accel_en ? level : 2'd0;
        shifted    = clkdiv >> eff_level;
        period     = (shifted == '0) ? DIV_W'(1) : shifted;
        terminal   = (cnt >= period - DIV_W'(1));
        next_phase = (state == RUN_R) ? phase + 2'd1 : phase - 2'd1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            level    <= '0;
            held     <= '0;
            phase    <= '0;
            steer    <= '0;
            position <= '0;
            stepped  <= 1'b0;
        end else begin
            stepped <= 1'b0;
            if (target != state) begin
                // Entry, reversal or release: restart timing but keep phase and position.
                state <= target;
                cnt   <= '0;
                level <= '0;
                held  <= '0;
            end else if (state != IDLE) begin
                if (terminal) begin
                    cnt      <= '0;
                    phase    <= next_phase;
                    steer    <= phase_to_ab(next_phase);
                    position <= (state == RUN_R) ? position + POS_W'(1) : position - POS_W'(1);
                    stepped  <= 1'b1;
                    if (accel_en) begin
                        held <= held + 3'd1;
                        if (held == 3'(ACCEL_STEPS - 1) && level < 2'(ACCEL_MAX_LEVEL)) begin
                            level <= level + 2'd1;
                        end
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/joy2quad_multi.sv
// Multi-channel digital-to-quadrature steering encoder: one independent
// joy2quad_chan per channel, outputs concatenated with channel 0 in the LSBs.
module joy2quad_multi
    import joy2quad_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16,
    parameter int POS_W    = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [DIV_W-1:0]          clkdiv,
    input  logic                      accel_en,
    input  logic [CHANNELS-1:0]       left,
    input  logic [CHANNELS-1:0]       right,
    output logic [2*CHANNELS-1:0]     steer,
    output logic [POS_W*CHANNELS-1:0] position,
    output logic [CHANNELS-1:0]       stepped
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        joy2quad_chan #(
            .DIV_W(DIV_W),
            .POS_W(POS_W)
        ) u_chan (
            .CLK      (CLK),
            .reset    (reset),
            .clkdiv   (clkdiv),
            .accel_en (accel_en),
            .left     (left[i]),
            .right    (right[i]),
            .steer    (steer[2*i +: 2]),
            .position (position[POS_W*i +: POS_W]),
            .stepped  (stepped[i])
        );
    end

endmodule

// File: doc/joy2quad_multi.md
# joy2quad_multi

Parameterised multi-channel digital-to-quadrature steering encoder: converts per-channel left/right button levels into emulated optical-wheel quadrature pairs (A,B) for arcade driving cores. Successor to the single-channel fixed-rate encoder. Adds a channel count, a runtime step period, an optional acceleration ramp and a per-channel position counter. Sits between the joystick/keyboard merge logic and the game core's steering inputs. It runs in the core's video-rate clock domain.

## Interface
Parameters:
- CHANNELS, 2, number of independent steering channels (1..4)
- DIV_W, 16, width of step-period counter and clkdiv input
- POS_W, 8, width of per-channel wrap-around position counter

Ports:
- CLK  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clkdiv  in  DIV_W  base step period in CLK cycles; 0 treated as 1
- accel_en  in  1  1 = acceleration ramp enabled, 0 = fixed rate
- left  in  CHANNELS  per-channel left request, level, synchronous to CLK
- right  in  CHANNELS  per-channel right request, level, synchronous to CLK
- steer  out  2*CHANNELS  channel n quadrature at [2n+1:2n] = {A,B}, registered
- position  out  POS_W*CHANNELS  channel n signed step count at [POS_W*(n+1)-1:POS_W*n], registered
- stepped  out  CHANNELS  one-cycle pulse coincident with each quadrature edge

## Operation
- Per-channel direction: dir = RIGHT if right&~left, LEFT if left&~right, else NONE (both or neither = NONE).
- Per-channel state machine: IDLE (dir NONE) and RUN_R / RUN_L.
  - IDLE -> RUN_x when dir becomes x: cnt <= 0, level <= 0, held <= 0.
  - RUN_x -> RUN_y (reversal, same cycle): cnt <= 0, level <= 0, held <= 0; no step that cycle.
  - RUN_x -> IDLE when dir NONE: cnt, level, held cleared; phase and position retained.
- Step period = max(1, clkdiv >> level). level is 0 when accel_en=0.
- In RUN, cnt increments each cycle; when cnt == period-1: cnt <= 0, step fires.
- Step: phase (2 bits) +1 for RUN_R, -1 for RUN_L, mod 4; position +1/-1, wraps mod 2^POS_W; stepped pulses.
- Phase-to-output: 0->AB=00, 1->01, 2->11, 3->10 (Gray; exactly one bit changes per step).
- Acceleration (accel_en=1): held counts steps in current run; every 8th step level increments, saturating at 3 (max rate clkdiv>>3). held wraps mod 8.
- accel_en changes take effect on the next period computation; level not cleared.
- clkdiv change mid-run: new period used from next comparison; if cnt >= new period-1, step fires on that cycle.

## Timing
- Reset: steer all 0, position all 0, stepped all 0, phase 0, all channels IDLE.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous); first step after release at full period.
- Direction first sampled at edge k: first steer change visible after edge k+period (cnt 0..period-1).
- steer, position and stepped update on the same edge; latency from terminal count is 0 extra cycles (registered outputs).
- Channels fully independent; simultaneous steps on all channels permitted.
- Period 1 (clkdiv 0 or 1): one step per cycle while held.

## Structure
- Package joy2quad_pkg: direction enum (NONE, RIGHT, LEFT), state enum (IDLE, RUN_R, RUN_L), phase-to-AB Gray lookup, ACCEL_STEPS=8, ACCEL_MAX_LEVEL=3.
- Sub-module joy2quad_chan: one channel (FSM, period counter, ramp, phase, position); top generates CHANNELS instances and concatenates outputs.

## Test plan
- Reset, clkdiv=4, accel_en=0, right[0] held 17 cycles -> steer[1:0] 00->01->11->10->00 at cycles 4,8,12,16; position[0]=4; stepped 4 pulses.
- left[0] held with clkdiv=2 from phase 0 -> steer 10 at cycle 2, 11 at 4; position[0]=-2 (0xFE); wraps to 0x7F...0x80 boundary correct after 2^POS_W steps.
- left and right both held -> no steps, state IDLE; release left -> RUN_R, first step clkdiv cycles later.
- accel_en=1, clkdiv=16, right held -> 8 steps at 16, 8 at 8, 8 at 4, then steady at 2-cycle period; release and repress -> period back to 16.
- Reversal right->left mid-period (cnt=3 of 8) -> no step on reversal cycle, next step 8 cycles later with phase decrement.
- Reset asserted asynchronously mid-run on channel 1 while channel 0 idle -> all outputs 0 before next CLK edge; clkdiv=0 after release -> one step per cycle.
